// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared receiver FSM states, parity modes and bit-timing helper
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous valid/ready FIFO with extra-MSB wrap pointers
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_valid = (wr_ptr != rd_ptr);
    assign rd_data  = mem[rd_ptr[AW-1:0]];
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_ready = !full || rd_ready;
    assign do_wr    = wr_valid && wr_ready;
    assign do_rd    = rd_valid && rd_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_ext.sv
// rtl/uart_rx_ext.sv - configurable UART receiver; UART_RX_FIFO_EN selects FIFO buffering
module uart_rx_ext
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);
    localparam int CPB  = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB) + 1;
    localparam int BW   = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_V0   = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_V1   = CW'(HALF);
    localparam logic [CW-1:0] CNT_MID  = CW'(HALF + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);

    if (CPB < 4) begin : g_err_cpb
        $error("uart_rx_ext: CLKS_PER_BIT must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_frame
        $error("uart_rx_ext: unsupported DATA_BITS or STOP_BITS");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_depth
        $error("uart_rx_ext: FIFO_DEPTH must be a power of two >= 2");
    end

    logic                 sync1, rx_s, rx_prev;
    rx_state_e            state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 v0, v1, vote, decide, wrap;
    logic                 frame_flag, parity_flag, frame_now, push;

    assign vote      = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
    assign decide    = (cnt == CNT_MID);
    assign wrap      = (cnt == CNT_LAST);
    assign push      = (state == ST_STOP) && decide && (idx == BW'(STOP_BITS - 1));
    assign frame_now = frame_flag | ~vote;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= serial_in;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            v0          <= 1'b0;
            v1          <= 1'b0;
            frame_flag  <= 1'b0;
            parity_flag <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + CW'(1);
            if (cnt == CNT_V0) v0 <= rx_s;
            if (cnt == CNT_V1) v1 <= rx_s;
            case (state)
                ST_IDLE: begin
                    cnt         <= '0;
                    idx         <= '0;
                    frame_flag  <= 1'b0;
                    parity_flag <= 1'b0;
                    if (rx_prev && !rx_s) state <= ST_START;
                end
                ST_START: begin
                    if (decide && vote) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (wrap) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (decide) begin
                        shreg <= {vote, shreg[DATA_BITS-1:1]};
                        idx   <= idx + BW'(1);
                    end
                    if (wrap && idx == BW'(DATA_BITS)) begin
                        idx   <= '0;
                        state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (decide) parity_flag <= ^shreg ^ vote ^ (PARITY == PAR_ODD);
                    if (wrap) state <= ST_STOP;
                end
                ST_STOP: begin
                    if (decide) begin
                        frame_flag <= frame_now;
                        // Leave mid-stop-bit so a start edge right after the stop bit is caught.
                        if (push) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end else begin
                            idx <= idx + BW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef UART_RX_FIFO_EN
    logic                 wr_ready;
    logic                 head_valid;
    logic [DATA_BITS+1:0] head;

    sync_fifo #(
        .WIDTH(DATA_BITS + 2),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_data ({parity_flag, frame_now, shreg}),
        .wr_valid(push),
        .wr_ready(wr_ready),
        .rd_data (head),
        .rd_valid(head_valid),
        .rd_ready(data_out_ready)
    );

    assign data_out_valid                      = head_valid;
    assign {parity_err, frame_err, data_out}   = head_valid ? head : '0;
    assign overrun                             = push && !wr_ready;
`else
    logic accept;

    assign accept  = push && (!data_out_valid || data_out_ready);
    assign overrun = push && !accept;

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_out_valid <= 1'b0;
            data_out       <= '0;
            frame_err      <= 1'b0;
            parity_err     <= 1'b0;
        end else if (accept) begin
            data_out_valid <= 1'b1;
            data_out       <= shreg;
            frame_err      <= frame_now;
            parity_err     <= parity_flag;
        end else if (data_out_ready) begin
            data_out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_ext.sv
// tb/tb_uart_rx_ext.sv - directed self-checking bench for uart_rx_ext
module tb_uart_rx_ext;
    import uart_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       rx_a, rx_b, rdy_a, rdy_b;
    logic [7:0] dout_a, dout_b;
    logic       val_a, val_b, fe_a, fe_b, pe_a, pe_b, ovr_a, ovr_b;

    int compared   = 0;
    int mismatched = 0;

    logic [9:0] q_a[$];
    logic [9:0] q_b[$];
    int         ovr_cnt_a = 0;
    int         vcnt_a    = 0;

    uart_rx_ext #(
        .CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .reset(reset), .serial_in(rx_a), .data_out(dout_a),
        .data_out_valid(val_a), .data_out_ready(rdy_a), .frame_err(fe_a),
        .parity_err(pe_a), .overrun(ovr_a)
    );

    uart_rx_ext #(
        .CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_b (
        .clk(clk), .reset(reset), .serial_in(rx_b), .data_out(dout_b),
        .data_out_valid(val_b), .data_out_ready(rdy_b), .frame_err(fe_b),
        .parity_err(pe_b), .overrun(ovr_b)
    );

    always @(negedge clk) begin
        if (val_a && rdy_a) q_a.push_back({pe_a, fe_a, dout_a});
        if (val_b && rdy_b) q_b.push_back({pe_b, fe_b, dout_b});
        if (ovr_a) ovr_cnt_a++;
        if (val_a) vcnt_a++;
    end

    task automatic set_line(input int which, input logic v);
        if (which == 0) rx_a = v;
        else rx_b = v;
    endtask

    // Holds one bit period; a glitch flips the line for the single cycle at the middle vote sample.
    task automatic drive_bit(input int which, input logic v, input bit glitch);
        set_line(which, v);
        if (glitch) begin
            repeat (9) @(negedge clk);
            set_line(which, ~v);
            @(negedge clk);
            set_line(which, v);
            repeat (6) @(negedge clk);
        end else begin
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic send_frame(input int which, input logic [7:0] data, input bit par_en,
                              input logic par_bit, input logic stop_val, input int glitch_bit);
        drive_bit(which, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, data[i], i == glitch_bit);
        if (par_en) drive_bit(which, par_bit, 1'b0);
        drive_bit(which, stop_val, 1'b0);
        set_line(which, 1'b1);
        repeat (16) @(negedge clk);
    endtask

    task automatic test_reset;
        compared++; if (val_a !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b expected 0", val_a); end
        compared++; if (dout_a !== 8'h00) begin mismatched++; $display("FAIL reset_data: got %h expected 00", dout_a); end
        compared++; if ({fe_a, pe_a} !== 2'b00) begin mismatched++; $display("FAIL reset_flags: got %b expected 00", {fe_a, pe_a}); end
        compared++; if (ovr_a !== 1'b0) begin mismatched++; $display("FAIL reset_overrun: got %b expected 0", ovr_a); end
        compared++; if (dut_a.state !== ST_IDLE) begin mismatched++; $display("FAIL reset_state: got %0d expected %0d", dut_a.state, ST_IDLE); end
    endtask

    task automatic test_basic;
        int start, vstart;
        logic [9:0] w;
        rdy_a = 1'b1;
        start = q_a.size(); vstart = vcnt_a;
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, -1);
        w = (q_a.size() > start) ? q_a[start] : 10'h3FF;
        compared++; if (q_a.size() - start !== 1) begin mismatched++; $display("FAIL basic_count: got %0d expected 1", q_a.size() - start); end
        compared++; if (w[7:0] !== 8'hA5) begin mismatched++; $display("FAIL basic_data: got %h expected a5", w[7:0]); end
        compared++; if (w[9:8] !== 2'b00) begin mismatched++; $display("FAIL basic_flags: got %b expected 00", w[9:8]); end
        compared++; if (vcnt_a - vstart !== 1) begin mismatched++; $display("FAIL basic_valid_cycles: got %0d expected 1", vcnt_a - vstart); end
    endtask

    task automatic test_parity;
        int start;
        logic [9:0] w;
        rdy_b = 1'b1;
        start = q_b.size();
        send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1, -1);
        w = (q_b.size() > start) ? q_b[start] : 10'h3FF;
        compared++; if (w[7:0] !== 8'h03) begin mismatched++; $display("FAIL parity_bad_data: got %h expected 03", w[7:0]); end
        compared++; if (w[9:8] !== 2'b10) begin mismatched++; $display("FAIL parity_bad_flags: got %b expected 10", w[9:8]); end
        start = q_b.size();
        send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1, -1);
        w = (q_b.size() > start) ? q_b[start] : 10'h3FF;
        compared++; if (w[7:0] !== 8'h03) begin mismatched++; $display("FAIL parity_ok_data: got %h expected 03", w[7:0]); end
        compared++; if (w[9:8] !== 2'b00) begin mismatched++; $display("FAIL parity_ok_flags: got %b expected 00", w[9:8]); end
    endtask

    task automatic test_framing;
        int start;
        logic [9:0] w;
        rdy_a = 1'b1;
        start = q_a.size();
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0, -1);
        w = (q_a.size() > start) ? q_a[start] : 10'h3FF;
        compared++; if (w[7:0] !== 8'h5A) begin mismatched++; $display("FAIL frame_bad_data: got %h expected 5a", w[7:0]); end
        compared++; if (w[9:8] !== 2'b01) begin mismatched++; $display("FAIL frame_bad_flags: got %b expected 01", w[9:8]); end
        start = q_a.size();
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, -1);
        w = (q_a.size() > start) ? q_a[start] : 10'h3FF;
        compared++; if (w[7:0] !== 8'h11) begin mismatched++; $display("FAIL frame_next_data: got %h expected 11", w[7:0]); end
        compared++; if (w[9:8] !== 2'b00) begin mismatched++; $display("FAIL frame_next_flags: got %b expected 00", w[9:8]); end
    endtask

    task automatic test_glitch;
        int start;
        logic [9:0] w;
        rdy_a = 1'b1;
        start = q_a.size();
        rx_a = 1'b0;
        repeat (5) @(negedge clk);
        rx_a = 1'b1;
        repeat (200) @(negedge clk);
        compared++; if (q_a.size() - start !== 0) begin mismatched++; $display("FAIL glitch_false_start: got %0d words expected 0", q_a.size() - start); end
        compared++; if (dut_a.state !== ST_IDLE) begin mismatched++; $display("FAIL glitch_state: got %0d expected %0d", dut_a.state, ST_IDLE); end
        start = q_a.size();
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1, 3);
        w = (q_a.size() > start) ? q_a[start] : 10'h3FF;
        compared++; if (w !== 10'h000) begin mismatched++; $display("FAIL glitch_vote: got %h expected 000", w); end
    endtask

    task automatic test_overrun;
        int start, obase;
        rdy_a = 1'b0;
        obase = ovr_cnt_a;
`ifdef UART_RX_FIFO_EN
        for (int i = 1; i <= 4; i++) send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1, -1);
        compared++; if (ovr_cnt_a - obase !== 0) begin mismatched++; $display("FAIL fifo_no_overrun: got %0d expected 0", ovr_cnt_a - obase); end
        send_frame(0, 8'h05, 1'b0, 1'b0, 1'b1, -1);
        compared++; if (ovr_cnt_a - obase !== 1) begin mismatched++; $display("FAIL fifo_overrun: got %0d expected 1", ovr_cnt_a - obase); end
        start = q_a.size();
        rdy_a = 1'b1;
        repeat (10) @(negedge clk);
        compared++; if (q_a.size() - start !== 4) begin mismatched++; $display("FAIL fifo_drain_count: got %0d expected 4", q_a.size() - start); end
        for (int i = 0; i < 4; i++) begin
            logic [9:0] w;
            w = (q_a.size() > start + i) ? q_a[start + i] : 10'h3FF;
            compared++; if (w !== 10'(i + 1)) begin mismatched++; $display("FAIL fifo_drain_%0d: got %h expected %h", i, w, 10'(i + 1)); end
        end
`else
        send_frame(0, 8'h01, 1'b0, 1'b0, 1'b1, -1);
        send_frame(0, 8'h02, 1'b0, 1'b0, 1'b1, -1);
        compared++; if (ovr_cnt_a - obase !== 1) begin mismatched++; $display("FAIL hold_overrun: got %0d expected 1", ovr_cnt_a - obase); end
        compared++; if ({val_a, dout_a} !== 9'h101) begin mismatched++; $display("FAIL hold_word: got %h expected 101", {val_a, dout_a}); end
        start = q_a.size();
        rdy_a = 1'b1;
        repeat (4) @(negedge clk);
        compared++; if (q_a.size() - start !== 1) begin mismatched++; $display("FAIL hold_drain_count: got %0d expected 1", q_a.size() - start); end
        compared++; if (((q_a.size() > start) ? q_a[start] : 10'h3FF) !== 10'h001) begin mismatched++; $display("FAIL hold_drain_word: got %h expected 001", (q_a.size() > start) ? q_a[start] : 10'h3FF); end
        compared++; if (val_a !== 1'b0) begin mismatched++; $display("FAIL hold_valid_drop: got %b expected 0", val_a); end
`endif
    endtask

    task automatic test_reset_mid;
        int start;
        logic [7:0] d;
        logic [9:0] w;
        rdy_a = 1'b1;
        d = 8'hF5;
        start = q_a.size();
        drive_bit(0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, d[i], 1'b0);
        rx_a = d[4];
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        compared++; if (dut_a.state !== ST_IDLE) begin mismatched++; $display("FAIL midreset_state: got %0d expected %0d", dut_a.state, ST_IDLE); end
        repeat (9) @(negedge clk);
        for (int i = 5; i < 8; i++) drive_bit(0, d[i], 1'b0);
        drive_bit(0, 1'b1, 1'b0);
        repeat (16) @(negedge clk);
        compared++; if (q_a.size() - start !== 0 || val_a !== 1'b0) begin mismatched++; $display("FAIL midreset_no_word: got %0d words valid %b expected 0 words valid 0", q_a.size() - start, val_a); end
        start = q_a.size();
        send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1, -1);
        w = (q_a.size() > start) ? q_a[start] : 10'h3FF;
        compared++; if (w !== 10'h0C3) begin mismatched++; $display("FAIL midreset_next: got %h expected 0c3", w); end
    endtask

    initial begin
        reset = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        rdy_a = 1'b0;
        rdy_b = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        test_reset;
        test_basic;
        test_parity;
        test_framing;
        test_glitch;
        test_overrun;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
